// File: rtl/mmio_timer_intc.sv
// mmio_timer_intc: memory-mapped 64-bit timer with compare interrupt.
//
// A free-running 64-bit mtime advances once every PRESCALE+1 enabled cycles.
// When mtime >= CMP while counting is enabled, the sticky PEND bit is set.
// ext_int is the registered level PEND & IE driven to the CPU.
//
// Register window (32 bytes at BASE_ADDR, word index addr[4:2]):
//   0 CTRL      bit0 EN, bit1 IE
//   1 PRESCALE  16 bits; a write also restarts the prescale counter
//   2 MTIME_LO  a load latches mtime[63:32] into the read shadow
//   3 MTIME_HI  loads return the shadow, stores write mtime[63:32]
//   4 CMP_LO
//   5 CMP_HI
//   6 STATUS    bit0 PEND, write-1-to-clear (a live match wins)
//   7 reserved  reads 0, writes ignored
//
// Bus handshake: there is no stall. A store is accepted at the rising edge
// where we & hit; a load is answered combinationally on rdata in the same
// cycle, and its side effect (shadow capture) happens at the edge where
// re & hit.
//
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous active-low reset
//   addr    in   [31:0] byte address (bits 1:0 ignored)
//   wdata   in   [31:0] store data
//   we      in   store strobe, qualified by hit
//   re      in   load strobe, qualified by hit
//   rdata   out  [31:0] combinational load data selected by addr[4:2]
//   hit     out  address falls inside the register window
//   ext_int out  registered interrupt request
module mmio_timer_intc #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_F000,
    parameter logic [15:0] PRESCALE_RST = 16'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        ext_int
);

    localparam logic [2:0] IDX_CTRL     = 3'd0;
    localparam logic [2:0] IDX_PRESCALE = 3'd1;
    localparam logic [2:0] IDX_MTIME_LO = 3'd2;
    localparam logic [2:0] IDX_MTIME_HI = 3'd3;
    localparam logic [2:0] IDX_CMP_LO   = 3'd4;
    localparam logic [2:0] IDX_CMP_HI   = 3'd5;
    localparam logic [2:0] IDX_STATUS   = 3'd6;

    // Architectural state
    logic        en;
    logic        ie;
    logic [15:0] prescale;
    logic [15:0] pre_cnt;
    logic [63:0] mtime;
    logic [63:0] cmp;
    logic        pend;
    logic [31:0] shadow;

    // Next-state values
    logic [15:0] pre_cnt_next;
    logic [63:0] mtime_next;
    logic        pend_next;
    logic        tick;
    logic        match;

    logic [2:0]  idx;
    logic        wr;
    logic        rd;

    // Byte lanes are not supported, so the low address bits carry no meaning.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^addr[1:0];

    assign hit = (addr[31:5] == BASE_ADDR[31:5]);
    assign idx = addr[4:2];
    assign wr  = we & hit;
    assign rd  = re & hit;

    // Compare on the current register values, not the ones about to be written.
    assign match = en & (mtime >= cmp);

    // Prescaler: a PRESCALE write restarts the count and produces no tick.
    always_comb begin
        tick         = 1'b0;
        pre_cnt_next = pre_cnt;
        if (wr && idx == IDX_PRESCALE) begin
            pre_cnt_next = 16'd0;
        end else if (en) begin
            if (pre_cnt == prescale) begin
                pre_cnt_next = 16'd0;
                tick         = 1'b1;
            end else begin
                pre_cnt_next = pre_cnt + 16'd1;
            end
        end
    end

    // A store to either half wins over the tick; no carry crosses halves.
    always_comb begin
        mtime_next = mtime;
        if (wr && idx == IDX_MTIME_LO) begin
            mtime_next = {mtime[63:32], wdata};
        end else if (wr && idx == IDX_MTIME_HI) begin
            mtime_next = {wdata, mtime[31:0]};
        end else if (tick) begin
            mtime_next = mtime + 64'd1;
        end
    end

    // Set has priority over the write-1-to-clear.
    always_comb begin
        pend_next = pend;
        if (wr && idx == IDX_STATUS && wdata[0]) begin
            pend_next = 1'b0;
        end
        if (match) begin
            pend_next = 1'b1;
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (idx)
            IDX_CTRL:     rdata = {30'd0, ie, en};
            IDX_PRESCALE: rdata = {16'd0, prescale};
            IDX_MTIME_LO: rdata = mtime[31:0];
            IDX_MTIME_HI: rdata = shadow;
            IDX_CMP_LO:   rdata = cmp[31:0];
            IDX_CMP_HI:   rdata = cmp[63:32];
            IDX_STATUS:   rdata = {31'd0, pend};
            default:      rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en       <= 1'b0;
            ie       <= 1'b0;
            prescale <= PRESCALE_RST;
            pre_cnt  <= 16'd0;
            mtime    <= 64'd0;
            cmp      <= 64'hFFFF_FFFF_FFFF_FFFF;
            pend     <= 1'b0;
            shadow   <= 32'd0;
            ext_int  <= 1'b0;
        end else begin
            pre_cnt <= pre_cnt_next;
            mtime   <= mtime_next;
            pend    <= pend_next;
            // IE is taken from the register, so enabling it with PEND already
            // set raises ext_int one edge after the CTRL store.
            ext_int <= pend_next & ie;

            if (wr && idx == IDX_CTRL) begin
                en <= wdata[0];
                ie <= wdata[1];
            end
            if (wr && idx == IDX_PRESCALE) begin
                prescale <= wdata[15:0];
            end
            if (wr && idx == IDX_CMP_LO) begin
                cmp[31:0] <= wdata;
            end
            if (wr && idx == IDX_CMP_HI) begin
                cmp[63:32] <= wdata;
            end
            // Snapshot the high half so a LO-then-HI read pair is coherent.
            if (rd && idx == IDX_MTIME_LO) begin
                shadow <= mtime[63:32];
            end
        end
    end

endmodule

// File: tb/tb_mmio_timer_intc.sv
// Testbench for mmio_timer_intc: directed scenarios with known answers plus
// a randomized register-traffic run checked against a cycle model.
module tb_mmio_timer_intc;

    localparam logic [31:0] BASE = 32'h0000_F000;
    localparam logic [15:0] PRST = 16'h0005;

    localparam logic [31:0] A_CTRL   = BASE + 32'h00;
    localparam logic [31:0] A_PRE    = BASE + 32'h04;
    localparam logic [31:0] A_LO     = BASE + 32'h08;
    localparam logic [31:0] A_HI     = BASE + 32'h0C;
    localparam logic [31:0] A_CMPLO  = BASE + 32'h10;
    localparam logic [31:0] A_CMPHI  = BASE + 32'h14;
    localparam logic [31:0] A_STATUS = BASE + 32'h18;
    localparam logic [31:0] A_RSVD   = BASE + 32'h1C;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;
    logic        hit;
    logic        ext_int;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] exp_q[$];

    mmio_timer_intc #(
        .BASE_ADDR    (BASE),
        .PRESCALE_RST (PRST)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .wdata   (wdata),
        .we      (we),
        .re      (re),
        .rdata   (rdata),
        .hit     (hit),
        .ext_int (ext_int)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // ---------------- reference model ----------------
    // Timer seen as "counted cycles -> ticks": mtime advances after every
    // PRESCALE+1 enabled cycles; the sticky flag follows mtime >= cmp.
    logic        m_en       = 1'b0;
    logic        m_ie       = 1'b0;
    int unsigned m_prescale = PRST;
    int unsigned m_phase    = 0;
    logic [63:0] m_mtime    = 64'd0;
    logic [63:0] m_cmp      = '1;
    logic        m_pend     = 1'b0;
    logic [31:0] m_shadow   = 32'd0;
    logic        m_ext      = 1'b0;

    function automatic logic m_hit(input logic [31:0] a);
        return a[31:5] == BASE[31:5];
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        case (a[4:2])
            3'd0: return {30'd0, m_ie, m_en};
            3'd1: return m_prescale;
            3'd2: return m_mtime[31:0];
            3'd3: return m_shadow;
            3'd4: return m_cmp[31:0];
            3'd5: return m_cmp[63:32];
            3'd6: return {31'd0, m_pend};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin : model
        logic        w;
        logic        r;
        int          i;
        logic        hit_now;
        logic        fire;
        logic        ticked;
        logic [63:0] t_now;
        if (!rst) begin
            m_en = 1'b0; m_ie = 1'b0; m_prescale = PRST; m_phase = 0;
            m_mtime = 64'd0; m_cmp = '1; m_pend = 1'b0; m_shadow = 32'd0;
            m_ext = 1'b0;
        end else begin
            hit_now = m_hit(addr);
            w = we & hit_now;
            r = re & hit_now;
            i = int'(addr[4:2]);
            t_now = m_mtime;
            fire = m_en && (t_now >= m_cmp);
            ticked = 1'b0;
            if (w && i == 1) begin
                m_prescale = wdata[15:0];
                m_phase = 0;
            end else if (m_en) begin
                m_phase = m_phase + 1;
                if (m_phase > m_prescale) begin
                    m_phase = 0;
                    ticked = 1'b1;
                end
            end
            if (w && i == 2)      m_mtime = {t_now[63:32], wdata};
            else if (w && i == 3) m_mtime = {wdata, t_now[31:0]};
            else if (ticked)      m_mtime = t_now + 64'd1;
            if (r && i == 2) m_shadow = t_now[63:32];
            if (w && i == 6 && wdata[0]) m_pend = 1'b0;
            if (fire) m_pend = 1'b1;
            m_ext = m_pend && m_ie;
            if (w && i == 0) begin
                m_en = wdata[0];
                m_ie = wdata[1];
            end
            if (w && i == 4) m_cmp[31:0]  = wdata;
            if (w && i == 5) m_cmp[63:32] = wdata;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; we = 1'b1; re = 1'b0;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; we = 1'b0; re = 1'b1;
        #1;
        d = rdata;
        @(posedge clk);
        #1;
        re = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] exp_v[5];
        logic [31:0] offs[5];
        offs  = '{A_CTRL, A_PRE, A_CMPLO, A_CMPHI, A_STATUS};
        exp_v = '{32'd0, {16'd0, PRST}, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        rst = 1'b0; we = 1'b0; re = 1'b0; addr = A_CTRL; wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (ext_int !== 1'b0) begin
            n_fail++; $display("FAIL reset_ext_int_held: got %b expected 0", ext_int);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            addr = offs[k];
            #1;
            n_cmp++;
            if (rdata !== exp_v[k]) begin
                n_fail++;
                $display("FAIL reset_read_%h: got %h expected %h", offs[k], rdata, exp_v[k]);
            end
        end
        addr = A_RSVD;
        #1;
        n_cmp++;
        if (rdata !== 32'd0 || hit !== 1'b1) begin
            n_fail++; $display("FAIL reserved_read: got %h hit %b expected 0 hit 1", rdata, hit);
        end
        addr = BASE + 32'h20;
        #1;
        n_cmp++;
        if (hit !== 1'b0) begin
            n_fail++; $display("FAIL hit_outside: got %b expected 0", hit);
        end
        n_cmp++;
        if (ext_int !== 1'b0) begin
            n_fail++; $display("FAIL reset_ext_int_after: got %b expected 0", ext_int);
        end
    endtask

    task automatic test_tick_rate();
        logic [31:0] v;
        logic [31:0] v2;
        bus_write(A_PRE, 32'd3);
        bus_write(A_CTRL, 32'd1);
        repeat (39) @(posedge clk);
        bus_write(A_CTRL, 32'd0);   // 40th enabled edge
        bus_read(A_LO, v);
        n_cmp++;
        if (v < 32'd9 || v > 32'd11 || v !== m_mtime[31:0]) begin
            n_fail++; $display("FAIL tick_rate: got %0d expected %0d", v, m_mtime[31:0]);
        end
        repeat (8) @(posedge clk);
        bus_read(A_LO, v2);
        n_cmp++;
        if (v2 !== v) begin
            n_fail++; $display("FAIL tick_hold: got %0d expected %0d", v2, v);
        end
    endtask

    task automatic test_interrupt();
        logic        seen;
        logic        early_bad;
        logic        ei;
        logic [31:0] lo;
        logic [31:0] v;
        bus_write(A_LO, 32'd0);
        bus_write(A_CMPLO, 32'd20);
        bus_write(A_CMPHI, 32'd0);
        bus_write(A_PRE, 32'd0);
        bus_write(A_CTRL, 32'd3);
        seen = 1'b0; early_bad = 1'b0; ei = 1'b0; lo = 32'd0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            addr = A_STATUS;
            #1;
            if (rdata[0] === 1'b1) begin
                seen = 1'b1;
                ei = ext_int;
                addr = A_LO;
                #1;
                lo = rdata;
            end else if (ext_int !== 1'b0) begin
                early_bad = 1'b1;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_fail++; $display("FAIL pend_timeout: got 0 expected 1 within 100 cycles");
        end
        n_cmp++;
        if (early_bad) begin
            n_fail++; $display("FAIL ext_int_early: got 1 expected 0 before PEND");
        end
        n_cmp++;
        if (lo !== 32'd21 || ei !== 1'b1) begin
            n_fail++; $display("FAIL pend_edge: got mtime %0d ext_int %b expected 21 1", lo, ei);
        end
        bus_write(A_STATUS, 32'd1);
        bus_read(A_STATUS, v);
        n_cmp++;
        if (v !== 32'd1 || ext_int !== 1'b1) begin
            n_fail++; $display("FAIL set_wins: got pend %h ext_int %b expected 1 1", v, ext_int);
        end
        bus_write(A_CMPLO, 32'hFFFF_FFFF);
        bus_write(A_STATUS, 32'd1);
        @(negedge clk);
        addr = A_STATUS;
        #1;
        n_cmp++;
        if (rdata !== 32'd0 || ext_int !== 1'b0) begin
            n_fail++; $display("FAIL pend_clear: got pend %h ext_int %b expected 0 0", rdata, ext_int);
        end
    endtask

    task automatic test_carry_shadow();
        logic [31:0] lo;
        logic [31:0] hi;
        bus_write(A_CTRL, 32'd0);
        bus_write(A_HI, 32'd0);
        bus_write(A_LO, 32'hFFFF_FFFE);
        bus_write(A_PRE, 32'd0);
        bus_write(A_CTRL, 32'd1);
        repeat (3) @(posedge clk);
        bus_read(A_LO, lo);
        bus_read(A_HI, hi);
        n_cmp++;
        if (lo !== 32'd1 || hi !== 32'd1) begin
            n_fail++; $display("FAIL carry_read: got hi %h lo %h expected 1 1", hi, lo);
        end
        bus_write(A_HI, 32'h55);
        bus_read(A_HI, hi);
        n_cmp++;
        if (hi !== 32'd1) begin
            n_fail++; $display("FAIL stale_shadow: got %h expected 1", hi);
        end
    endtask

    task automatic test_collision();
        logic [31:0] v;
        bus_write(A_LO, 32'd5);
        bus_read(A_LO, v);
        n_cmp++;
        if (v !== 32'd5) begin
            n_fail++; $display("FAIL write_over_tick: got %0d expected 5", v);
        end
        bus_read(A_LO, v);
        n_cmp++;
        if (v !== 32'd6) begin
            n_fail++; $display("FAIL tick_resumes: got %0d expected 6", v);
        end
        bus_read(A_HI, v);
        n_cmp++;
        if (v !== 32'h55) begin
            n_fail++; $display("FAIL no_carry_into_hi: got %h expected 55", v);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] v;
        bus_write(A_CMPHI, 32'd0);
        bus_write(A_CMPLO, 32'd0);
        bus_write(A_CTRL, 32'd3);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (ext_int !== 1'b1) begin
            n_fail++; $display("FAIL ext_int_before_reset: got %b expected 1", ext_int);
        end
        #2;
        rst = 1'b0;
        addr = A_CTRL;
        #1;
        n_cmp++;
        if (ext_int !== 1'b0 || rdata !== 32'd0) begin
            n_fail++; $display("FAIL async_clear_ctrl: got ext_int %b ctrl %h expected 0 0", ext_int, rdata);
        end
        addr = A_LO;
        #1;
        n_cmp++;
        if (rdata !== 32'd0) begin
            n_fail++; $display("FAIL async_clear_mtime: got %h expected 0", rdata);
        end
        addr = A_STATUS;
        #1;
        n_cmp++;
        if (rdata !== 32'd0) begin
            n_fail++; $display("FAIL async_clear_pend: got %h expected 0", rdata);
        end
        addr = A_CMPLO;
        #1;
        n_cmp++;
        if (rdata !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL async_clear_cmp: got %h expected ffffffff", rdata);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        bus_read(A_LO, v);
        n_cmp++;
        if (v !== 32'd0) begin
            n_fail++; $display("FAIL idle_after_reset: got %h expected 0", v);
        end
    endtask

    task automatic test_random();
        int          idx;
        int          op;
        logic [31:0] a;
        logic [31:0] e;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            idx = $urandom_range(0, 7);
            a = BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a = a + 32'h20;
            op = $urandom_range(0, 3);
            case (idx)
                0, 1:    wdata = $urandom_range(0, 3);
                2:       wdata = $urandom_range(0, 60);
                4:       wdata = $urandom_range(0, 80);
                3, 5:    wdata = $urandom_range(0, 1);
                default: wdata = $urandom;
            endcase
            addr = a;
            we = (op == 1 || op == 3);
            re = (op >= 2);
            #1;
            n_cmp++;
            if (hit !== m_hit(a)) begin
                n_fail++; $display("FAIL rnd_hit[%0d]: got %b expected %b", k, hit, m_hit(a));
            end
            if (m_hit(a)) begin
                exp_q.push_back(m_read(a));
                e = exp_q.pop_front();
                n_cmp++;
                if (rdata !== e) begin
                    n_fail++; $display("FAIL rnd_rdata[%0d] idx %0d: got %h expected %h", k, idx, rdata, e);
                end
            end
            n_cmp++;
            if (ext_int !== m_ext) begin
                n_fail++; $display("FAIL rnd_ext_int[%0d]: got %b expected %b", k, ext_int, m_ext);
            end
        end
        @(negedge clk);
        we = 1'b0;
        re = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_tick_rate();
        test_interrupt();
        test_carry_shadow();
        test_collision();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
